// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage : execute stage of the 5-stage MIPS pipeline.
//
// Registers the decode->execute bus, evaluates the single-cycle ALU, issues the
// data-SRAM request for loads/stores, owns HI/LO and a sequential 32-step
// restoring divider for div/divu. While a divide is in flight the stage raises
// stallreq_for_ex so the pipeline controller freezes the front end.
//
// Ports
//   clk              in   1     rising-edge clock
//   rst              in   1     asynchronous active-high reset
//   stall            in   6     stall vector, bit2 = decode, bit3 = execute
//   id_to_ex_bus     in   159   {pc,inst,alu_op,src1,src2,ram_en,ram_wen,
//                                rf_we,rf_waddr,sel_rf_res,data1,data2}
//   stallreq_for_ex  out  1     divide in progress
//   ex_is_load       out  1     registered instruction is lw
//   ex_to_mem_bus    out  76    {pc,ram_en,ram_wen,sel_rf_res,rf_we,rf_waddr,ex_result}
//   ex_to_rf_bus     out  38    {rf_we,rf_waddr,ex_result} forwarding to decode
//   data_sram_*      out        data-SRAM request (en, wen, addr, wdata)
// -----------------------------------------------------------------------------
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int EX_TO_RF_WD  = 38,
    parameter int DIV_ITERS    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic                    stallreq_for_ex,
    output logic                    ex_is_load,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    localparam int CNT_W = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

    // ---------------- pipeline register ----------------
    logic [ID_TO_EX_WD-1:0] bus_q;

    // Decode->execute register: bubble when decode stops but execute advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_q <= '0;
        end else if (stall[2] && !stall[3]) begin
            bus_q <= '0;
        end else if (!stall[2]) begin
            bus_q <= id_to_ex_bus;
        end else begin
            bus_q <= bus_q;
        end
    end

    logic [31:0] pc_s, inst_s, data1_s, data2_s;
    logic [11:0] alu_op_s;
    logic [2:0]  src1_sel_s;
    logic [3:0]  src2_sel_s, ram_wen_s;
    logic        ram_en_s, rf_we_s, sel_rf_res_s;
    logic [4:0]  rf_waddr_s;

    assign {pc_s, inst_s, alu_op_s, src1_sel_s, src2_sel_s, ram_en_s, ram_wen_s,
            rf_we_s, rf_waddr_s, sel_rf_res_s, data1_s, data2_s} = bus_q;

    // Stall bits owned by other stages and rs/rt fields are not needed here.
    logic unused_s;
    assign unused_s = ^{stall[5:4], stall[1:0], inst_s[25:16]};

    // ---------------- instruction decode for HI/LO/div ----------------
    logic is_special_s, is_mfhi_s, is_mflo_s, is_mthi_s, is_mtlo_s;
    logic is_div_s, is_divu_s, is_anydiv_s;

    assign is_special_s = (inst_s[31:26] == 6'b000000);
    assign is_mfhi_s    = is_special_s && (inst_s[5:0] == 6'b010000);
    assign is_mthi_s    = is_special_s && (inst_s[5:0] == 6'b010001);
    assign is_mflo_s    = is_special_s && (inst_s[5:0] == 6'b010010);
    assign is_mtlo_s    = is_special_s && (inst_s[5:0] == 6'b010011);
    assign is_div_s     = is_special_s && (inst_s[5:0] == 6'b011010);
    assign is_divu_s    = is_special_s && (inst_s[5:0] == 6'b011011);
    assign is_anydiv_s  = is_div_s || is_divu_s;
    assign ex_is_load   = (inst_s[31:26] == 6'b100011);

    // ---------------- ALU ----------------
    logic [31:0] imm_sext_s, imm_zext_s, src1_s, src2_s, alu_res_s;
    logic [4:0]  shamt_s;

    assign imm_sext_s = {{16{inst_s[15]}}, inst_s[15:0]};
    assign imm_zext_s = {16'h0000, inst_s[15:0]};

    assign src1_s = ({32{src1_sel_s[0]}} & data1_s)
                  | ({32{src1_sel_s[1]}} & pc_s)
                  | ({32{src1_sel_s[2]}} & {27'd0, inst_s[10:6]});
    assign src2_s = ({32{src2_sel_s[0]}} & data2_s)
                  | ({32{src2_sel_s[1]}} & imm_sext_s)
                  | ({32{src2_sel_s[2]}} & 32'd8)
                  | ({32{src2_sel_s[3]}} & imm_zext_s);
    assign shamt_s = src1_s[4:0];

    // One-hot alu_op: AND-OR of every candidate, so an all-zero op yields 0.
    always_comb begin
        alu_res_s = ({32{alu_op_s[11]}} & (src1_s + src2_s))
                  | ({32{alu_op_s[10]}} & (src1_s - src2_s))
                  | ({32{alu_op_s[9]}}  & {31'd0, ($signed(src1_s) < $signed(src2_s))})
                  | ({32{alu_op_s[8]}}  & {31'd0, (src1_s < src2_s)})
                  | ({32{alu_op_s[7]}}  & (src1_s & src2_s))
                  | ({32{alu_op_s[6]}}  & ~(src1_s | src2_s))
                  | ({32{alu_op_s[5]}}  & (src1_s | src2_s))
                  | ({32{alu_op_s[4]}}  & (src1_s ^ src2_s))
                  | ({32{alu_op_s[3]}}  & (src2_s << shamt_s))
                  | ({32{alu_op_s[2]}}  & (src2_s >> shamt_s))
                  | ({32{alu_op_s[1]}}  & 32'($signed(src2_s) >>> shamt_s))
                  | ({32{alu_op_s[0]}}  & {src2_s[15:0], 16'h0000});
    end

    // ---------------- divider ----------------
    div_state_e       state_q;
    logic [31:0]      quo_q, rem_q, dvsr_q, hi_q, lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_quo_q, neg_rem_q;

    logic [32:0] trial_s;
    logic        ge_s;
    logic [31:0] rem_next_s, abs_a_s, abs_b_s, quo_fix_s, rem_fix_s;

    assign abs_a_s = (is_div_s && data1_s[31]) ? (32'd0 - data1_s) : data1_s;
    assign abs_b_s = (is_div_s && data2_s[31]) ? (32'd0 - data2_s) : data2_s;

    // Restoring step: shift the next dividend bit into the partial remainder.
    assign trial_s    = {rem_q, quo_q[31]};
    assign ge_s       = (trial_s >= {1'b0, dvsr_q});
    assign rem_next_s = ge_s ? (trial_s[31:0] - dvsr_q) : trial_s[31:0];

    assign quo_fix_s = neg_quo_q ? (32'd0 - quo_q) : quo_q;
    assign rem_fix_s = neg_rem_q ? (32'd0 - rem_q) : rem_q;

    assign stallreq_for_ex = ((state_q == DIV_IDLE) && is_anydiv_s) || (state_q == DIV_RUN);

    // Divider FSM and datapath: latch operands, iterate, then hand off in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (is_anydiv_s) begin
                        state_q   <= DIV_RUN;
                        quo_q     <= abs_a_s;
                        rem_q     <= 32'd0;
                        dvsr_q    <= abs_b_s;
                        cnt_q     <= '0;
                        neg_quo_q <= is_div_s && (data1_s[31] ^ data2_s[31]);
                        neg_rem_q <= is_div_s && data1_s[31];
                    end else begin
                        state_q <= DIV_IDLE;
                    end
                end
                DIV_RUN: begin
                    quo_q <= {quo_q[30:0], ge_s};
                    rem_q <= rem_next_s;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                        state_q <= DIV_DONE;
                    end else begin
                        state_q <= DIV_RUN;
                    end
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

    // HI/LO: divider result wins in DONE, otherwise mthi/mtlo when execute advances.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (state_q == DIV_DONE) begin
            hi_q <= rem_fix_s;
            lo_q <= quo_fix_s;
        end else if (!stall[3] && is_mthi_s) begin
            hi_q <= data1_s;
        end else if (!stall[3] && is_mtlo_s) begin
            lo_q <= data1_s;
        end else begin
            hi_q <= hi_q;
            lo_q <= lo_q;
        end
    end

    // ---------------- outputs ----------------
    logic [31:0] ex_result_s;

    assign ex_result_s = is_mfhi_s ? hi_q : (is_mflo_s ? lo_q : alu_res_s);

    assign ex_to_mem_bus = {pc_s, ram_en_s, ram_wen_s, sel_rf_res_s, rf_we_s, rf_waddr_s, ex_result_s};
    assign ex_to_rf_bus  = {rf_we_s, rf_waddr_s, ex_result_s};

    // Memory request is suppressed while the divider holds the stage.
    assign data_sram_en    = stallreq_for_ex ? 1'b0  : (ram_en_s || (ram_wen_s != 4'h0));
    assign data_sram_wen   = stallreq_for_ex ? 4'h0  : ram_wen_s;
    assign data_sram_addr  = stallreq_for_ex ? 32'd0 : ex_result_s;
    assign data_sram_wdata = stallreq_for_ex ? 32'd0 : data2_s;

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: hand-computed vectors for the ALU, memory
// request, pipeline-register stalls, HI/LO moves and the sequential divider.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall, stall_m;
    logic [158:0] id_to_ex_bus;
    logic         stallreq_for_ex, ex_is_load;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;

    int n_cmp = 0;
    int n_err = 0;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .stallreq_for_ex (stallreq_for_ex),
        .ex_is_load      (ex_is_load),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    // The pipeline controller freezes stages 0..3 whenever execute requests it.
    assign stall = stall_m | (stallreq_for_ex ? 6'b001111 : 6'b000000);

    task automatic check_val(input string tag, input logic [75:0] got, input logic [75:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ren,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic [31:0] d1,
                                        input logic [31:0] d2);
        return {pc, inst, op, s1, s2, ren, wen, we, wa, 1'b0, d1, d2};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] sa, input logic [5:0] func);
        return {6'b000000, 5'd1, 5'd2, 5'd3, sa, func};
    endfunction

    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [11:0] OP_SUB  = 12'h400;
    localparam logic [11:0] OP_SLT  = 12'h200;
    localparam logic [11:0] OP_SLTU = 12'h100;
    localparam logic [11:0] OP_SRA  = 12'h002;
    localparam logic [11:0] OP_LUI  = 12'h001;

    logic [158:0] addu_b, sw_b, mflo_b, mfhi_b;

    // Issue a divide, count the stall cycles, then read LO and HI back.
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int n;
        id_to_ex_bus = mk(32'h0000_0200, rtype(5'd0, sgn ? 6'b011010 : 6'b011011),
                          12'h000, 3'b001, 4'b0001, 1'b1, 4'h0, 1'b0, 5'd0, a, b);
        tick();
        check_val({tag, "_sram_gated"}, {75'd0, data_sram_en}, 76'd0);
        id_to_ex_bus = mflo_b;
        n = 0;
        while (stallreq_for_ex && n < 100) begin
            n++;
            tick();
        end
        check_val({tag, "_stall_cycles"}, 76'(n), 76'd33);
        tick();
        check_val({tag, "_lo"}, 76'(ex_to_rf_bus), 76'({1'b1, 5'd4, exp_lo}));
        id_to_ex_bus = mfhi_b;
        tick();
        check_val({tag, "_hi"}, 76'(ex_to_rf_bus), 76'({1'b1, 5'd5, exp_hi}));
    endtask

    initial begin
        rst          = 1'b1;
        stall_m      = 6'b000000;
        id_to_ex_bus = '0;
        addu_b = mk(32'h0000_0010, rtype(5'd0, 6'b100001), OP_ADD, 3'b001, 4'b0001,
                    1'b0, 4'h0, 1'b1, 5'd9, 32'd7, 32'hFFFF_FFFD);
        sw_b   = mk(32'h0000_0040, {6'b101011, 5'd1, 5'd2, 16'hFFFC}, OP_ADD, 3'b001, 4'b0010,
                    1'b0, 4'hF, 1'b0, 5'd0, 32'h0000_0100, 32'hDEAD_BEEF);
        mflo_b = mk(32'h0000_0300, rtype(5'd0, 6'b010010), 12'h000, 3'b000, 4'b0000,
                    1'b0, 4'h0, 1'b1, 5'd4, 32'd0, 32'd0);
        mfhi_b = mk(32'h0000_0304, rtype(5'd0, 6'b010000), 12'h000, 3'b000, 4'b0000,
                    1'b0, 4'h0, 1'b1, 5'd5, 32'd0, 32'd0);

        repeat (2) tick();
        check_val("rst_mem_bus", ex_to_mem_bus, 76'd0);
        check_val("rst_misc", 76'({stallreq_for_ex, ex_is_load, data_sram_en, data_sram_wen,
                                   data_sram_addr, ex_to_rf_bus}), 76'd0);
        rst = 1'b0;

        // addu 7 + -3
        id_to_ex_bus = addu_b;
        tick();
        check_val("addu_rf", 76'(ex_to_rf_bus), 76'({1'b1, 5'd9, 32'd4}));

        // sw: address 0x100 + (-4)
        id_to_ex_bus = sw_b;
        tick();
        check_val("sw_sram", 76'({data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}),
                  76'({1'b1, 4'hF, 32'h0000_00FC, 32'hDEAD_BEEF}));
        check_val("sw_mem_bus", ex_to_mem_bus,
                  {32'h0000_0040, 1'b0, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_00FC});

        // lw flags load and enables the SRAM with no write strobes
        id_to_ex_bus = mk(32'h0000_0044, {6'b100011, 5'd1, 5'd2, 16'h0008}, OP_ADD, 3'b001,
                          4'b0010, 1'b1, 4'h0, 1'b1, 5'd2, 32'h0000_1000, 32'd0);
        tick();
        check_val("lw", 76'({ex_is_load, data_sram_en, data_sram_wen, data_sram_addr}),
                  76'({1'b1, 1'b1, 4'h0, 32'h0000_1008}));

        // sra by sa=4, sub wrap, slt/sltu, lui, zero op
        id_to_ex_bus = mk(32'd0, rtype(5'd4, 6'b000011), OP_SRA, 3'b100, 4'b0001,
                          1'b0, 4'h0, 1'b1, 5'd1, 32'd0, 32'h8000_0000);
        tick();
        check_val("sra", 76'(ex_to_rf_bus[31:0]), 76'(32'hF800_0000));
        id_to_ex_bus = mk(32'd0, rtype(5'd0, 6'b100011), OP_SUB, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b1, 5'd1, 32'd0, 32'd1);
        tick();
        check_val("sub_wrap", 76'(ex_to_rf_bus[31:0]), 76'(32'hFFFF_FFFF));
        id_to_ex_bus = mk(32'd0, rtype(5'd0, 6'b101010), OP_SLT, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b1, 5'd1, 32'hFFFF_FFFF, 32'd1);
        tick();
        check_val("slt", 76'(ex_to_rf_bus[31:0]), 76'd1);
        id_to_ex_bus = mk(32'd0, rtype(5'd0, 6'b101011), OP_SLTU, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b1, 5'd1, 32'hFFFF_FFFF, 32'd1);
        tick();
        check_val("sltu", 76'(ex_to_rf_bus[31:0]), 76'd0);
        id_to_ex_bus = mk(32'd0, {6'b001111, 5'd0, 5'd2, 16'h1234}, OP_LUI, 3'b000, 4'b1000,
                          1'b0, 4'h0, 1'b1, 5'd2, 32'd0, 32'd0);
        tick();
        check_val("lui", 76'(ex_to_rf_bus[31:0]), 76'(32'h1234_0000));
        id_to_ex_bus = mk(32'd0, 32'h2000_0000, 12'h000, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b1, 5'd1, 32'd5, 32'd6);
        tick();
        check_val("zero_op", 76'(ex_to_rf_bus[31:0]), 76'd0);

        // mthi then mfhi
        id_to_ex_bus = mk(32'd0, rtype(5'd0, 6'b010001), 12'h000, 3'b000, 4'b0000,
                          1'b0, 4'h0, 1'b0, 5'd0, 32'h0000_0055, 32'd0);
        tick();
        id_to_ex_bus = mfhi_b;
        tick();
        check_val("mthi_mfhi", 76'(ex_to_rf_bus[31:0]), 76'h55);

        // Bubble, then hold
        id_to_ex_bus = sw_b;
        tick();
        stall_m = 6'b000100;
        tick();
        check_val("bubble_mem_bus", ex_to_mem_bus, 76'd0);
        check_val("bubble_sram_en", 76'(data_sram_en), 76'd0);
        stall_m = 6'b000000;
        tick();
        stall_m = 6'b001100;
        id_to_ex_bus = addu_b;
        tick();
        check_val("hold_mem_bus", ex_to_mem_bus,
                  {32'h0000_0040, 1'b0, 4'hF, 1'b0, 1'b0, 5'd0, 32'h0000_00FC});
        check_val("hold_sram_addr", 76'(data_sram_addr), 76'h0FC);
        stall_m = 6'b000000;

        // Divides
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu_ff_16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'h0000_000F);
        run_div("divu_by0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

        // Reset in the middle of a division
        id_to_ex_bus = mk(32'h0000_0400, rtype(5'd0, 6'b011011), 12'h000, 3'b001, 4'b0001,
                          1'b0, 4'h0, 1'b0, 5'd0, 32'd100, 32'd7);
        tick();
        repeat (11) tick();
        check_val("mid_div_busy", 76'(stallreq_for_ex), 76'd1);
        rst = 1'b1;
        #1;
        check_val("rst_abort_stallreq", 76'(stallreq_for_ex), 76'd0);
        check_val("rst_abort_rf_bus", 76'(ex_to_rf_bus), 76'd0);
        tick();
        rst = 1'b0;
        id_to_ex_bus = mfhi_b;
        tick();
        check_val("rst_hi", 76'(ex_to_rf_bus), 76'({1'b1, 5'd5, 32'd0}));
        check_val("rst_idle", 76'(stallreq_for_ex), 76'd0);
        id_to_ex_bus = mflo_b;
        tick();
        check_val("rst_lo", 76'(ex_to_rf_bus), 76'({1'b1, 5'd4, 32'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
